// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART-facing ALU framing stages (RX collector, TX result framer).
package alu_uart_pkg;

  // Marks the start of every frame on the wire.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Width of the operation-select field.
  localparam int unsigned OPCODE_W = 8;

  // Receive framing states; the TX framer walks the same sequence in reverse.
  typedef enum logic [2:0] {
    IDLE,
    OPC,
    A,
    B,
    OUT
  } collector_state_t;

endpackage

// File: rtl/alu_operand_collector_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while running and emits a one-cycle
// registered pulse once TIMEOUT_CYCLES cycles elapse without a clear.
module gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            expired_q, expired_d;

  // Next count: hold at zero while stopped or cleared, wrap to zero on expiry.
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (!run || clear) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d     = '0;
      expired_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/alu_operand_collector.sv
// Receive-side framing stage: hunts for the sync byte in the UART RX stream, assembles an
// opcode plus two big-endian N-bit operands, and offers them to the ALU over valid/ready.
module alu_operand_collector
  import alu_uart_pkg::*;
#(
  parameter int unsigned N              = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [N-1:0]        op_a,
  output logic [N-1:0]        op_b,
  output logic [OPCODE_W-1:0] opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_err,
  output logic                overrun
);

  localparam int unsigned NumBytes = N / 8;
  localparam int unsigned CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NumBytes - 1);

  collector_state_t state_q, state_d;

  logic [CntW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [OPCODE_W-1:0] sh_op_q, sh_op_d;
  logic [N-1:0]        sh_a_q, sh_a_d;
  logic [N-1:0]        sh_b_q, sh_b_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [N-1:0]        op_a_q, op_a_d;
  logic [N-1:0]        op_b_q, op_b_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  logic [N-1:0] a_shifted;
  logic [N-1:0] b_shifted;
  logic         last_byte;
  logic         timer_run;
  logic         timer_clear;
  logic         timer_expired;

  // Shadow registers with the incoming byte appended at the LSB end (big-endian assembly).
  if (N == 8) begin : g_single_byte
    assign a_shifted = rx_data;
    assign b_shifted = rx_data;
  end else begin : g_multi_byte
    assign a_shifted = {sh_a_q[N-9:0], rx_data};
    assign b_shifted = {sh_b_q[N-9:0], rx_data};
  end

  assign last_byte = (byte_cnt_q == CntLast);

  // The timer only watches gaps inside a frame; any accepted byte restarts it.
  assign timer_run   = (state_q == OPC) || (state_q == A) || (state_q == B);
  assign timer_clear = rx_valid;

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (timer_run),
    .clear  (timer_clear),
    .expired(timer_expired)
  );

  // Framing FSM next-state, shadow assembly and output-register loads.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    sh_op_d     = sh_op_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    opcode_d    = opcode_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = OPC;
        end
      end

      OPC: begin
        if (rx_valid) begin
          sh_op_d    = rx_data;
          byte_cnt_d = '0;
          state_d    = A;
        end else if (timer_expired) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          sh_op_d     = '0;
          sh_a_d      = '0;
          sh_b_d      = '0;
          byte_cnt_d  = '0;
        end
      end

      A: begin
        if (rx_valid) begin
          sh_a_d = a_shifted;
          if (last_byte) begin
            byte_cnt_d = '0;
            state_d    = B;
          end else begin
            byte_cnt_d = byte_cnt_q + CntW'(1);
          end
        end else if (timer_expired) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          sh_op_d     = '0;
          sh_a_d      = '0;
          sh_b_d      = '0;
          byte_cnt_d  = '0;
        end
      end

      B: begin
        if (rx_valid) begin
          sh_b_d = b_shifted;
          if (last_byte) begin
            // Final byte goes straight into op_b so the frame is presented on this edge.
            byte_cnt_d  = '0;
            state_d     = OUT;
            opcode_d    = sh_op_q;
            op_a_d      = sh_a_q;
            op_b_d      = b_shifted;
            out_valid_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + CntW'(1);
          end
        end else if (timer_expired) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          sh_op_d     = '0;
          sh_a_d      = '0;
          sh_b_d      = '0;
          byte_cnt_d  = '0;
        end
      end

      OUT: begin
        // Bytes arriving while the frame awaits acceptance are lost, even a sync byte.
        if (rx_valid) begin
          overrun_d = 1'b1;
        end
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        byte_cnt_d  = '0;
      end
    endcase
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      sh_op_q     <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      opcode_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      sh_op_q     <= sh_op_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      opcode_q    <= opcode_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign opcode    = opcode_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
